// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_pkg
// Purpose  : Shared types and constants for the sequenced single-precision
//            floating-point adder (state encoding, special values, flag
//            layout and a flag-packing helper).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        ROUND = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int EXP_BIAS       = 127;
    localparam int EXP_MAX        = 2 * EXP_BIAS + 1;   // 255, all-ones exponent
    localparam int INT_MANT_WIDTH = 27;                 // hidden + 23 + G + R + S
    localparam int ALIGN_SAT      = INT_MANT_WIDTH;     // beyond this B is pure sticky

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    // flags_out = {invalid, overflow, inexact}
    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    function automatic logic [2:0] make_flags(input logic invalid,
                                              input logic overflow,
                                              input logic inexact);
        logic [2:0] f;
        f                = 3'b000;
        f[FLAG_INVALID]  = invalid;
        f[FLAG_OVERFLOW] = overflow;
        f[FLAG_INEXACT]  = inexact;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_special_case.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_special_case
// Purpose  : Combinational classifier for operand pairs that bypass the
//            arithmetic datapath (NaN, infinities, zeros with flush-to-zero).
// Ports    : op_a, op_b      - raw IEEE-754 operands
//            is_special      - pair resolves without arithmetic
//            special_result  - the resolved result when is_special
//            invalid         - NaN input or +Inf + -Inf
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_special_case
    import fp_add_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  is_special,
    output logic [DATA_WIDTH-1:0] special_result,
    output logic                  invalid
);

    logic [EXPO_WIDTH-1:0] w_exp_a;
    logic [EXPO_WIDTH-1:0] w_exp_b;
    logic                  w_frac_a_nz;
    logic                  w_frac_b_nz;
    logic                  w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;

    assign w_exp_a     = op_a[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign w_exp_b     = op_b[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign w_frac_a_nz = |op_a[MENT_WIDTH-1:0];
    assign w_frac_b_nz = |op_b[MENT_WIDTH-1:0];

    assign w_nan_a  = (&w_exp_a) &  w_frac_a_nz;
    assign w_nan_b  = (&w_exp_b) &  w_frac_b_nz;
    assign w_inf_a  = (&w_exp_a) & ~w_frac_a_nz;
    assign w_inf_b  = (&w_exp_b) & ~w_frac_b_nz;
    // Zero exponent covers denormals as well: they are flushed to zero.
    assign w_zero_a = ~(|w_exp_a);
    assign w_zero_b = ~(|w_exp_b);

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        invalid        = 1'b0;
        if (w_nan_a || w_nan_b ||
            (w_inf_a && w_inf_b && (op_a[DATA_WIDTH-1] != op_b[DATA_WIDTH-1]))) begin
            is_special     = 1'b1;
            special_result = DATA_WIDTH'(QNAN);
            invalid        = 1'b1;
        end else if (w_inf_a) begin
            is_special     = 1'b1;
            special_result = op_a;
        end else if (w_inf_b) begin
            is_special     = 1'b1;
            special_result = op_b;
        end else if (w_zero_a && w_zero_b) begin
            is_special     = 1'b1;
            special_result = {op_a[DATA_WIDTH-1] & op_b[DATA_WIDTH-1], {(DATA_WIDTH-1){1'b0}}};
        end else if (w_zero_a) begin
            is_special     = 1'b1;
            special_result = op_b;
        end else if (w_zero_b) begin
            is_special     = 1'b1;
            special_result = op_a;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_sequencer
// Purpose  : Multi-cycle IEEE-754 single-precision adder. An FSM walks
//            CMP -> ALIGN -> ADD -> NORM -> ROUND -> DONE, aligning and
//            normalising one bit per cycle. FTZ, round-to-nearest-even.
// Ports    : clk_in, rst_n_in (async, active-low)
//            valid_in/ready_out, floating1_in, floating2_in - operand handshake
//            valid_out/ready_in, floating_addition_out, flags_out
//                {invalid, overflow, inexact} - result handshake
//            busy_out - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_sequencer
    import fp_add_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] floating1_in,
    input  logic [DATA_WIDTH-1:0] floating2_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] floating_addition_out,
    output logic [2:0]            flags_out,
    output logic                  busy_out
);

    localparam int MW = INT_MANT_WIDTH;
    localparam int EW = EXPO_WIDTH + 1;   // one spare bit to see exponent overflow

    state_t                r_state, w_next_state;
    logic [DATA_WIDTH-1:0] r_op_a, r_op_b, r_result;
    logic [2:0]            r_flags;
    logic                  r_special, r_sign_a, r_sign_b;
    logic [EW-1:0]         r_exp;
    logic [MW-1:0]         r_mant_a, r_mant_b;
    logic [4:0]            r_shift;
    logic [MW:0]           r_sum;     // bit MW is the adder carry

    // ---------------- compare / swap ----------------
    logic                  w_a_ge;
    logic [DATA_WIDTH-1:0] w_big, w_small;
    logic [EXPO_WIDTH-1:0] w_exp_big, w_exp_small, w_exp_diff;
    logic [4:0]            w_shift;
    logic                  w_is_special, w_special_invalid;
    logic [DATA_WIDTH-1:0] w_special_result;

    // Magnitude order is just an unsigned compare of {exponent, fraction}.
    assign w_a_ge      = r_op_a[DATA_WIDTH-2:0] >= r_op_b[DATA_WIDTH-2:0];
    assign w_big       = w_a_ge ? r_op_a : r_op_b;
    assign w_small     = w_a_ge ? r_op_b : r_op_a;
    assign w_exp_big   = w_big[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign w_exp_small = w_small[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign w_exp_diff  = w_exp_big - w_exp_small;
    assign w_shift     = (w_exp_diff >= EXPO_WIDTH'(ALIGN_SAT)) ? 5'(ALIGN_SAT)
                                                                 : w_exp_diff[4:0];

    fp_add_special_case #(
        .DATA_WIDTH (DATA_WIDTH),
        .MENT_WIDTH (MENT_WIDTH),
        .EXPO_WIDTH (EXPO_WIDTH)
    ) u_special (
        .op_a           (r_op_a),
        .op_b           (r_op_b),
        .is_special     (w_is_special),
        .special_result (w_special_result),
        .invalid        (w_special_invalid)
    );

    // ---------------- round (round-to-nearest-even) ----------------
    logic                  w_guard, w_round, w_sticky, w_lsb, w_inc;
    logic [MENT_WIDTH+1:0] w_rnd;
    logic [EW-1:0]         w_rnd_exp;
    logic [MENT_WIDTH-1:0] w_rnd_frac;
    logic                  w_overflow, w_inexact;
    logic [DATA_WIDTH-1:0] w_rnd_result;

    assign w_guard    = r_sum[2];
    assign w_round    = r_sum[1];
    assign w_sticky   = r_sum[0];
    assign w_lsb      = r_sum[3];
    assign w_inc      = w_guard & (w_round | w_sticky | w_lsb);
    assign w_rnd      = {1'b0, r_sum[MW-1:3]} + {{(MENT_WIDTH+1){1'b0}}, w_inc};
    // A carry out of the increment means the mantissa became 10.000...0.
    assign w_rnd_exp  = r_exp + {{EXPO_WIDTH{1'b0}}, w_rnd[MENT_WIDTH+1]};
    assign w_rnd_frac = w_rnd[MENT_WIDTH+1] ? w_rnd[MENT_WIDTH:1] : w_rnd[MENT_WIDTH-1:0];
    assign w_overflow = w_rnd_exp >= EW'(EXP_MAX);
    assign w_inexact  = w_guard | w_round | w_sticky | w_overflow;
    assign w_rnd_result = w_overflow ? (r_sign_a ? DATA_WIDTH'(NEG_INF) : DATA_WIDTH'(POS_INF))
                                     : {r_sign_a, w_rnd_exp[EXPO_WIDTH-1:0], w_rnd_frac};

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (valid_in) w_next_state = CMP;
            // Special results take the ROUND slot so they leave two edges
            // after acceptance through the same output path.
            CMP:   if (w_is_special)             w_next_state = ROUND;
                   else if (w_exp_diff != '0)    w_next_state = ALIGN;
                   else                          w_next_state = ADD;
            ALIGN: if (r_shift == 5'd1) w_next_state = ADD;
            ADD:   w_next_state = NORM;
            NORM:  if (r_sum[MW])               w_next_state = ROUND;
                   else if (r_sum == '0)        w_next_state = DONE;
                   else if (!r_sum[MW-1]) begin
                       if (r_exp == EW'(1))     w_next_state = DONE;
                   end else                     w_next_state = ROUND;
            ROUND: w_next_state = DONE;
            DONE:  if (ready_in) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_special <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_exp     <= '0;
            r_mant_a  <= '0;
            r_mant_b  <= '0;
            r_shift   <= '0;
            r_sum     <= '0;
        end else begin
            case (r_state)
                IDLE: if (valid_in) begin
                    r_op_a <= floating1_in;
                    r_op_b <= floating2_in;
                end
                CMP: begin
                    r_special <= w_is_special;
                    if (w_is_special) begin
                        r_result <= w_special_result;
                        r_flags  <= make_flags(w_special_invalid, 1'b0, 1'b0);
                    end else begin
                        r_sign_a <= w_big[DATA_WIDTH-1];
                        r_sign_b <= w_small[DATA_WIDTH-1];
                        r_exp    <= {1'b0, w_exp_big};
                        r_mant_a <= {1'b1, w_big[MENT_WIDTH-1:0], 3'b000};
                        r_mant_b <= {1'b1, w_small[MENT_WIDTH-1:0], 3'b000};
                        r_shift  <= w_shift;
                    end
                end
                ALIGN: begin
                    // Bits leaving the bottom collapse into the sticky bit.
                    r_mant_b <= {1'b0, r_mant_b[MW-1:2], r_mant_b[1] | r_mant_b[0]};
                    r_shift  <= r_shift - 5'd1;
                end
                ADD: begin
                    // A has the larger magnitude, so the difference is never negative.
                    if (r_sign_a == r_sign_b) r_sum <= {1'b0, r_mant_a} + {1'b0, r_mant_b};
                    else                      r_sum <= {1'b0, r_mant_a} - {1'b0, r_mant_b};
                end
                NORM: begin
                    if (r_sum[MW]) begin
                        r_sum <= {1'b0, r_sum[MW:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + EW'(1);
                    end else if (r_sum == '0) begin
                        r_result <= '0;
                        r_flags  <= '0;
                    end else if (!r_sum[MW-1]) begin
                        if (r_exp == EW'(1)) begin
                            // Would become denormal: flush to signed zero.
                            r_result <= {r_sign_a, {(DATA_WIDTH-1){1'b0}}};
                            r_flags  <= '0;
                        end else begin
                            r_sum <= r_sum << 1;
                            r_exp <= r_exp - EW'(1);
                        end
                    end
                end
                ROUND: if (!r_special) begin
                    r_result <= w_rnd_result;
                    r_flags  <= make_flags(1'b0, w_overflow, w_inexact);
                end
                default: ;
            endcase
        end
    end

    assign ready_out             = (r_state == IDLE);
    assign busy_out              = (r_state != IDLE);
    assign valid_out             = (r_state == DONE);
    assign floating_addition_out = r_result;
    assign flags_out             = r_flags;

endmodule
`default_nettype wire
